// File: rtl/vend_pkg.sv
// Shared types, coin values and slot price lookup for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISP,
        ST_CHANGE
    } state_t;

    // Coin values in half-units.
    localparam int unsigned ONE  = 2;
    localparam int unsigned HALF = 1;

    // Map a slot index to its price in half-units.
    function automatic int unsigned price_of(
        input logic [1:0]  slot,
        input int unsigned p0,
        input int unsigned p1,
        input int unsigned p2,
        input int unsigned p3
    );
        case (slot)
            2'd0:    return p0;
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_pacer.sv
// Paces change ejection: one pulse on the first active cycle, then one
// every CHANGE_GAP cycles while active stays high.
module vend_change_pacer #(
    parameter int CHANGE_GAP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    output logic pulse
);

    localparam int GW = $clog2(CHANGE_GAP + 1);

    logic [GW-1:0] gap_cnt;

    assign pulse = active && (gap_cnt == '0);

    // Gap counter: cleared on start, reloaded after each pulse, counts down between pulses.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            gap_cnt <= '0;
        end else if (start || !active) begin
            gap_cnt <= '0;
        end else if (gap_cnt == '0) begin
            gap_cnt <= GW'(CHANGE_GAP - 1);
        end else begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Credit and sequencing controller for a four-slot vending machine: coin
// credit, selection check, dispenser handshake with timeout, paced change.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE0       = 5,
    parameter int unsigned PRICE1       = 6,
    parameter int unsigned PRICE2       = 8,
    parameter int unsigned PRICE3       = 3,
    parameter int unsigned CREDIT_MAX   = 20,
    parameter int          CW           = 5,
    parameter int unsigned DISP_TIMEOUT = 16,
    parameter int          CHANGE_GAP   = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          pi_money_one,
    input  logic          pi_money_half,
    input  logic          pi_sel_vld,
    input  logic [1:0]    pi_sel,
    input  logic          pi_cancel,
    input  logic          pi_disp_done,
    output logic          po_disp_req,
    output logic [1:0]    po_disp_slot,
    output logic          po_change,
    output logic [CW-1:0] po_credit,
    output logic          po_coin_reject,
    output logic          po_sel_err,
    output logic          po_fault,
    output logic          po_busy
);

    localparam int TW = $clog2(DISP_TIMEOUT + 1);
    localparam logic [CW:0] MAX_V  = (CW+1)'(CREDIT_MAX);
    localparam logic [CW:0] HALF_V = (CW+1)'(HALF);

    state_t        state, state_n;
    logic [CW-1:0] credit, credit_n;
    logic [1:0]    slot, slot_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic          reject_q, reject_n;
    logic          sel_err_q, sel_err_n;
    logic          fault_q, fault_n;
    logic          change_start, change_pulse;

    logic [CW:0]   coin_val, base, sum_all, sum_half;
    logic [CW-1:0] sel_price, disp_price;

    assign coin_val   = (pi_money_one  ? (CW+1)'(ONE)  : '0)
                      + (pi_money_half ? (CW+1)'(HALF) : '0);
    assign sel_price  = CW'(price_of(pi_sel, PRICE0, PRICE1, PRICE2, PRICE3));
    assign disp_price = CW'(price_of(slot, PRICE0, PRICE1, PRICE2, PRICE3));

    vend_change_pacer #(
        .CHANGE_GAP (CHANGE_GAP)
    ) u_pacer (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .start  (change_start),
        .active (state == ST_CHANGE),
        .pulse  (change_pulse)
    );

    assign change_start = (state_n == ST_CHANGE) && (state != ST_CHANGE);

    // Next-state, next-credit and pulse decisions for the controller.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves a value held and no latch is inferred.
        state_n   = state;
        credit_n  = credit;
        slot_n    = slot;
        tmo_n     = tmo_cnt;
        reject_n  = 1'b0;
        sel_err_n = 1'b0;
        fault_n   = 1'b0;
        base      = {1'b0, credit};
        sum_all   = '0;
        sum_half  = '0;

        case (state)
            ST_IDLE, ST_CREDIT: begin
                // Cancel wins over a same-cycle selection; IDLE ignores cancel.
                if (pi_cancel && state == ST_CREDIT) begin
                    state_n = ST_CHANGE;
                end else if (pi_sel_vld) begin
                    if (credit >= sel_price) begin
                        base    = {1'b0, credit - sel_price};
                        slot_n  = pi_sel;
                        tmo_n   = '0;
                        state_n = ST_DISP;
                    end else begin
                        sel_err_n = 1'b1;
                    end
                end
                // Coins are added on top of the post-selection credit; if the
                // whole amount overflows, fall back to accepting just the half coin.
                sum_all  = base + coin_val;
                sum_half = base + HALF_V;
                if (sum_all <= MAX_V) begin
                    credit_n = sum_all[CW-1:0];
                end else begin
                    reject_n = 1'b1;
                    if (pi_money_half && sum_half <= MAX_V)
                        credit_n = sum_half[CW-1:0];
                    else
                        credit_n = base[CW-1:0];
                end
                if (state == ST_IDLE && state_n == ST_IDLE && credit_n != '0)
                    state_n = ST_CREDIT;
            end

            ST_DISP: begin
                reject_n = pi_money_one | pi_money_half;
                if (pi_disp_done) begin
                    state_n = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end else if (tmo_cnt == TW'(DISP_TIMEOUT - 1)) begin
                    // Dispenser never answered: refund the price and pay it all back.
                    fault_n  = 1'b1;
                    credit_n = credit + disp_price;
                    state_n  = ST_CHANGE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end

            ST_CHANGE: begin
                reject_n = pi_money_one | pi_money_half;
                if (change_pulse) begin
                    credit_n = credit - 1'b1;
                    if (credit == CW'(1))
                        state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // Controller registers: state, credit, dispensed slot, timeout and output pulses.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            credit    <= '0;
            slot      <= '0;
            tmo_cnt   <= '0;
            reject_q  <= 1'b0;
            sel_err_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_n;
            credit    <= credit_n;
            slot      <= slot_n;
            tmo_cnt   <= tmo_n;
            reject_q  <= reject_n;
            sel_err_q <= sel_err_n;
            fault_q   <= fault_n;
        end
    end

    assign po_disp_req    = (state == ST_DISP);
    assign po_disp_slot   = po_disp_req ? slot : 2'd0;
    assign po_change      = change_pulse;
    assign po_credit      = credit;
    assign po_coin_reject = reject_q;
    assign po_sel_err     = sel_err_q;
    assign po_fault       = fault_q;
    assign po_busy        = (state == ST_DISP) || (state == ST_CHANGE);

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a scoreboard of expected dispense
// slots and expected credit at each change pulse.
module tb_vend_controller;

    localparam int CW  = 5;
    localparam int GAP = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          pi_money_one = 1'b0, pi_money_half = 1'b0;
    logic          pi_sel_vld = 1'b0, pi_cancel = 1'b0, pi_disp_done = 1'b0;
    logic [1:0]    pi_sel = 2'd0;
    logic          po_disp_req, po_change, po_coin_reject, po_sel_err, po_fault, po_busy;
    logic [1:0]    po_disp_slot;
    logic [CW-1:0] po_credit;

    int errors = 0;
    int checks = 0;
    int slot_q[$];
    int credit_q[$];

    vend_controller dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .pi_money_one   (pi_money_one),
        .pi_money_half  (pi_money_half),
        .pi_sel_vld     (pi_sel_vld),
        .pi_sel         (pi_sel),
        .pi_cancel      (pi_cancel),
        .pi_disp_done   (pi_disp_done),
        .po_disp_req    (po_disp_req),
        .po_disp_slot   (po_disp_slot),
        .po_change      (po_change),
        .po_credit      (po_credit),
        .po_coin_reject (po_coin_reject),
        .po_sel_err     (po_sel_err),
        .po_fault       (po_fault),
        .po_busy        (po_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic coin(input logic one, input logic half);
        pi_money_one  = one;
        pi_money_half = half;
        tick();
        pi_money_one  = 1'b0;
        pi_money_half = 1'b0;
    endtask

    task automatic select(input logic [1:0] s, input logic cancel);
        pi_sel_vld = 1'b1;
        pi_sel     = s;
        pi_cancel  = cancel;
        tick();
        pi_sel_vld = 1'b0;
        pi_cancel  = 1'b0;
    endtask

    task automatic cancel_req();
        pi_cancel = 1'b1;
        tick();
        pi_cancel = 1'b0;
    endtask

    task automatic pulse_done();
        pi_disp_done = 1'b1;
        tick();
        pi_disp_done = 1'b0;
    endtask

    // Wait for a dispense request and compare its slot to the scoreboard.
    task automatic wait_req(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (po_disp_req) break;
            tick();
        end
        check("req_seen", po_disp_req, 1);
        if (slot_q.size() > 0) check("disp_slot", po_disp_slot, slot_q.pop_front());
        else check("disp_slot_unexpected", po_disp_req, 0);
    endtask

    // Consume change pulses until the controller leaves CHANGE.
    task automatic drain_change(input int budget);
        int last;
        last = -1;
        for (int i = 0; i < budget; i++) begin
            if (!po_busy) break;
            if (po_change) begin
                if (credit_q.size() == 0) begin
                    check("change_extra", po_change, 0);
                end else begin
                    check("change_credit", po_credit, credit_q.pop_front());
                    if (last >= 0) check("change_gap", i - last, GAP);
                    last = i;
                end
            end
            tick();
        end
        check("change_left", credit_q.size(), 0);
        check("busy_after_change", po_busy, 0);
        check("credit_after_change", po_credit, 0);
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        check("rst_credit", po_credit, 0);
        check("rst_req", po_disp_req, 0);
        check("rst_busy", po_busy, 0);
        check("rst_change", po_change, 0);
        sys_rst = 1'b0;
        tick();

        // Selection with zero credit in IDLE
        select(2'd3, 1'b0);
        check("idle_sel_err", po_sel_err, 1);
        check("idle_sel_req", po_disp_req, 0);

        // Test 1: 1 + 1 + 0.5 = 5, buy slot 0, done 3 cycles after request
        coin(1'b1, 1'b0);
        check("t1_credit_a", po_credit, 2);
        coin(1'b1, 1'b0);
        coin(1'b0, 1'b1);
        check("t1_credit_b", po_credit, 5);
        slot_q.push_back(0);
        select(2'd0, 1'b0);
        check("t1_req_latency", po_disp_req, 1);
        check("t1_credit_after_sel", po_credit, 0);
        wait_req(4);
        tick();
        tick();
        pulse_done();
        check("t1_req_dropped", po_disp_req, 0);
        check("t1_busy", po_busy, 0);
        check("t1_no_change", po_change, 0);
        check("t1_credit_end", po_credit, 0);

        // Test 2: credit 6, buy slot 3, expect 3 change pulses
        coin(1'b1, 1'b0);
        coin(1'b1, 1'b0);
        coin(1'b1, 1'b0);
        check("t2_credit", po_credit, 6);
        slot_q.push_back(3);
        credit_q.push_back(3);
        credit_q.push_back(2);
        credit_q.push_back(1);
        select(2'd3, 1'b0);
        wait_req(4);
        tick();
        pulse_done();
        check("t2_req_dropped", po_disp_req, 0);
        drain_change(40);

        // Test 3: insufficient credit, then cancel beating selection
        coin(1'b1, 1'b0);
        select(2'd1, 1'b0);
        check("t3_sel_err", po_sel_err, 1);
        check("t3_credit", po_credit, 2);
        check("t3_no_req", po_disp_req, 0);
        tick();
        check("t3_sel_err_single", po_sel_err, 0);
        credit_q.push_back(2);
        credit_q.push_back(1);
        select(2'd1, 1'b1);
        check("t3_cancel_no_err", po_sel_err, 0);
        check("t3_cancel_busy", po_busy, 1);
        drain_change(20);

        // Test 4: credit ceiling
        for (int i = 0; i < 9; i++) coin(1'b1, 1'b0);
        coin(1'b0, 1'b1);
        check("t4_credit19", po_credit, 19);
        coin(1'b1, 1'b0);
        check("t4_reject_one", po_coin_reject, 1);
        check("t4_credit_hold", po_credit, 19);
        coin(1'b1, 1'b1);
        check("t4_reject_both", po_coin_reject, 1);
        check("t4_credit20", po_credit, 20);
        tick();
        check("t4_reject_single", po_coin_reject, 0);
        for (int c = 20; c >= 1; c--) credit_q.push_back(c);
        cancel_req();
        drain_change(100);

        // Test 5: dispense timeout and full refund
        coin(1'b1, 1'b0);
        coin(1'b1, 1'b0);
        coin(1'b0, 1'b1);
        slot_q.push_back(0);
        for (int c = 5; c >= 1; c--) credit_q.push_back(c);
        select(2'd0, 1'b0);
        wait_req(4);
        n = 0;
        while (!po_fault && n < 40) begin
            tick();
            n++;
        end
        check("t5_fault_seen", po_fault, 1);
        check("t5_fault_cycles", n, 16);
        check("t5_req_dropped", po_disp_req, 0);
        check("t5_refund", po_credit, 5);
        drain_change(40);

        // Test 6: coins rejected in DISP, reset in the middle of CHANGE
        for (int i = 0; i < 4; i++) coin(1'b1, 1'b0);
        slot_q.push_back(1);
        select(2'd1, 1'b0);
        wait_req(4);
        coin(1'b1, 1'b0);
        check("t6_disp_reject", po_coin_reject, 1);
        check("t6_disp_credit", po_credit, 2);
        pulse_done();
        check("t6_first_change", po_change, 1);
        check("t6_first_credit", po_credit, 2);
        tick();
        sys_rst = 1'b1;
        #1;
        check("t6_rst_credit", po_credit, 0);
        check("t6_rst_busy", po_busy, 0);
        check("t6_rst_change", po_change, 0);
        check("t6_rst_req", po_disp_req, 0);
        tick();
        sys_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (po_change) n++;
            tick();
        end
        check("t6_no_pulses", n, 0);
        check("t6_idle_busy", po_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Credit and sequencing controller for the single-product vending datapath, extended to four priced slots.
- Accumulates coin credit from the 1-unit and half-unit coin inputs and validates a slot selection against price.
- Sequences the shared dispenser through a request/done handshake, then paces change ejection one half-unit coin at a time.
- Sits between the coin acceptor/keypad front end and the dispenser and change-motor drivers.

Parameters:
- PRICE0, 5, slot 0 price in half-units (2.5)
- PRICE1, 6, slot 1 price in half-units
- PRICE2, 8, slot 2 price in half-units
- PRICE3, 3, slot 3 price in half-units
- CREDIT_MAX, 20, maximum credit in half-units
- CW, 5, credit width; must satisfy 2^CW > CREDIT_MAX
- DISP_TIMEOUT, 16, cycles to wait for dispense done before fault
- CHANGE_GAP, 4, cycles between change pulses (≥2)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- pi_money_one  in  1  1-cycle pulse, 1-unit coin (+2 half-units)
- pi_money_half  in  1  1-cycle pulse, half-unit coin (+1)
- pi_sel_vld  in  1  1-cycle selection strobe
- pi_sel  in  2  slot index, valid with pi_sel_vld
- pi_cancel  in  1  1-cycle cancel/refund request
- pi_disp_done  in  1  dispenser completion pulse
- po_disp_req  out  1  dispense request, level
- po_disp_slot  out  2  slot being dispensed, stable while po_disp_req
- po_change  out  1  1-cycle pulse, eject one half-unit coin
- po_credit  out  CW  current credit in half-units
- po_coin_reject  out  1  1-cycle pulse, a coin was refused
- po_sel_err  out  1  1-cycle pulse, insufficient credit
- po_fault  out  1  1-cycle pulse, dispense timeout
- po_busy  out  1  high in DISP or CHANGE

Behaviour:
- Reset: all outputs 0, credit 0, state IDLE. Reset takes effect immediately in any state, including mid-DISP and mid-CHANGE. Any pending change is discarded.
- States are IDLE, CREDIT, DISP and CHANGE.
- Coins in IDLE/CREDIT:
  - Add value = 2·one + half. Both coins in the same cycle adds 3.
  - The total is evaluated as a whole. If credit+value > CREDIT_MAX, try accepting only the half coin (if present). Anything refused produces po_coin_reject the next cycle.
  - When credit becomes non-zero, go IDLE→CREDIT.
- Coins in DISP/CHANGE: always refused, po_coin_reject pulses, credit unchanged.
- Selection in CREDIT (pi_sel_vld, no cancel), checked against the credit registered before this cycle's coin:
  - credit ≥ PRICE[pi_sel]: credit -= price and state goes to DISP. po_disp_req and po_disp_slot are asserted the following cycle.
  - credit < PRICE[pi_sel]: po_sel_err pulses and the state is unchanged.
  - A coin arriving in the same cycle is still accepted and added, subject to the CREDIT_MAX rule.
- Selection in IDLE with 0 credit: po_sel_err pulses.
- Cancel in CREDIT goes to CHANGE; cancel has priority over selection in the same cycle. Cancel in IDLE, DISP or CHANGE is ignored.
- DISP:
  - po_disp_req is held until pi_disp_done is sampled high, then drops the next cycle.
  - Timeout counter starts at request assertion. pi_disp_done on the timeout cycle counts as success.
  - On done: credit > 0 → CHANGE, else → IDLE.
  - If DISP_TIMEOUT cycles pass with no done: po_fault pulses, po_disp_req drops, credit += price (full refund), → CHANGE.
- CHANGE:
  - po_change pulses on the first CHANGE cycle, then every CHANGE_GAP cycles. Each pulse decrements credit by 1 in the same cycle.
  - When credit reaches 0 → IDLE. No pulse is emitted after the last decrement.
- pi_disp_done outside DISP is ignored. po_credit is the registered credit, updated one cycle after the event.

Decomposition:
- Package vend_pkg holds:
  - the state enum;
  - coin value constants ONE=2, HALF=1;
  - the price-lookup function.
- One sub-module, vend_change_pacer:
  - owns the CHANGE_GAP counter;
  - interface: start/active in, pulse out.
- The main FSM, credit register and timeout counter stay in vend_controller.

Test Plan:
- Reset, then one, one, half (credit=5), select 0, pi_disp_done 3 cycles after req → po_disp_req high one cycle after select, low after done. Credit 0, no po_change, back to IDLE.
- Credit 6, select 3 → dispense, done, then 3 po_change pulses spaced 4 cycles. po_credit 3→2→1→0, then IDLE, po_busy low.
- Credit 2, select 1 → single po_sel_err pulse, credit stays 2, no po_disp_req. Select together with cancel at credit 2 → 2 change pulses, no po_sel_err.
- Credit 19, pi_money_one → po_coin_reject, credit 19. Then both coins same cycle → half accepted, credit 20, po_coin_reject pulse.
- Credit 5, select 0, pi_disp_done never → po_fault after 16 cycles, po_disp_req drops, then 5 change pulses.
- Credit 8, select 1, done, sys_rst asserted after first change pulse → all outputs 0 at once, credit 0, no further pulses. Coins during DISP are rejected.
